// File: rtl/pzbcm_sram_pkg.sv
// Shared types and helpers for the pzbcm SRAM reader slice.
package pzbcm_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } pzbcm_sram_reader_state_e;

  // Width needed to hold an outstanding count in 0..max_outstanding.
  function automatic int unsigned credit_width(int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/pzbcm_sram_reader_if.sv
// Command / SRAM request / SRAM response / stream bundle around the SRAM reader.
interface pzbcm_sram_reader_if #(
  parameter int unsigned POINTER_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned LENGTH_WIDTH  = 8
);
  logic                     clear;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [POINTER_WIDTH-1:0] cmd_pointer;
  logic [LENGTH_WIDTH-1:0]  cmd_length;
  logic                     read_valid;
  logic                     read_ready;
  logic [POINTER_WIDTH-1:0] read_pointer;
  logic                     read_info;
  logic                     read_data_valid;
  logic                     read_data_ready;
  logic [DATA_WIDTH-1:0]    read_data;
  logic                     read_data_info;
  logic                     data_valid;
  logic                     data_ready;
  logic [DATA_WIDTH-1:0]    data;
  logic                     last;
  logic                     busy;

  modport master (
    input  clear, cmd_valid, cmd_pointer, cmd_length,
           read_ready, read_data_valid, read_data, read_data_info, data_ready,
    output cmd_ready, read_valid, read_pointer, read_info,
           read_data_ready, data_valid, data, last, busy
  );

  modport slave (
    output clear, cmd_valid, cmd_pointer, cmd_length,
           read_ready, read_data_valid, read_data, read_data_info, data_ready,
    input  cmd_ready, read_valid, read_pointer, read_info,
           read_data_ready, data_valid, data, last, busy
  );
endinterface

// File: rtl/pzbcm_sram_reader_credit.sv
// Saturating up/down counter tracking requests issued but not yet delivered.
module pzbcm_sram_reader_credit
  import pzbcm_sram_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clear_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned         CW        = credit_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0]       MAX_COUNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i && (count_q != MAX_COUNT)) begin
      count_d = count_q + CW'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign full_o  = (count_q == MAX_COUNT);
  assign empty_o = (count_q == '0);
endmodule

// File: rtl/pzbcm_sram_reader.sv
// Turns (pointer, length) commands into SRAM word reads and streams the
// returned words downstream with credit-based flow control.
module pzbcm_sram_reader
  import pzbcm_sram_pkg::*;
#(
  parameter int unsigned POINTER_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LENGTH_WIDTH    = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     i_read_clk,
  input  logic                     i_read_rst_n,
  input  logic                     i_clear,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [POINTER_WIDTH-1:0] i_cmd_pointer,
  input  logic [LENGTH_WIDTH-1:0]  i_cmd_length,
  output logic                     o_read_valid,
  input  logic                     i_read_ready,
  output logic [POINTER_WIDTH-1:0] o_read_pointer,
  output logic                     o_read_info,
  input  logic                     i_read_data_valid,
  output logic                     o_read_data_ready,
  input  logic [DATA_WIDTH-1:0]    i_read_data,
  input  logic                     i_read_info,
  output logic                     o_data_valid,
  input  logic                     i_data_ready,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_last,
  output logic                     o_busy
);
  pzbcm_sram_reader_state_e state_q, state_d;
  logic [POINTER_WIDTH-1:0] pointer_q, pointer_d;
  logic [LENGTH_WIDTH-1:0]  remaining_q, remaining_d;
  logic                     credit_full;
  logic                     credit_empty;
  logic                     cmd_accept;
  logic                     request_hs;
  logic                     stream_hs;

  // Responses bypass the reader entirely: no added latency.
  assign o_data_valid      = i_read_data_valid;
  assign o_data            = i_read_data;
  assign o_last            = i_read_info;
  assign o_read_data_ready = i_data_ready;

  assign cmd_accept = i_cmd_valid && o_cmd_ready && !i_clear;
  assign request_hs = o_read_valid && i_read_ready;
  assign stream_hs  = i_read_data_valid && i_data_ready;

  pzbcm_sram_reader_credit #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_credit (
    .i_clk   (i_read_clk),
    .i_rst_n (i_read_rst_n),
    .clear_i (i_clear),
    .inc_i   (request_hs),
    .dec_i   (stream_hs),
    .full_o  (credit_full),
    .empty_o (credit_empty)
  );

  always_ff @(posedge i_read_clk or negedge i_read_rst_n) begin
    if (!i_read_rst_n) begin
      state_q     <= IDLE;
      pointer_q   <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      pointer_q   <= pointer_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pointer_d   = pointer_q;
    remaining_d = remaining_q;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          state_d     = ISSUE;
          pointer_d   = i_cmd_pointer;
          remaining_d = i_cmd_length;
        end
      end
      ISSUE: begin
        if (request_hs) begin
          pointer_d = pointer_q + POINTER_WIDTH'(1);
          if (remaining_q == '0) state_d     = DRAIN;
          else                   remaining_d = remaining_q - LENGTH_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (stream_hs && i_read_info) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_clear) begin
      state_d     = IDLE;
      pointer_d   = '0;
      remaining_d = '0;
    end
  end

  // Last-word flag is qualified by ISSUE so it reads 0 while idle/reset.
  always_comb begin
    o_cmd_ready    = (state_q == IDLE);
    o_read_valid   = (state_q == ISSUE) && !credit_full && !i_clear;
    o_read_pointer = pointer_q;
    o_read_info    = (state_q == ISSUE) && (remaining_q == '0);
    o_busy         = (state_q != IDLE) || !credit_empty;
  end
endmodule

// File: tb/tb_pzbcm_sram_reader.sv
// Directed bench for pzbcm_sram_reader with a one-cycle-latency SRAM model.
module tb_pzbcm_sram_reader;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;

  pzbcm_sram_reader_if #(.POINTER_WIDTH(8), .DATA_WIDTH(32), .LENGTH_WIDTH(8)) bus ();

  pzbcm_sram_reader #(
    .POINTER_WIDTH   (8),
    .DATA_WIDTH      (32),
    .LENGTH_WIDTH    (8),
    .MAX_OUTSTANDING (4)
  ) dut (
    .i_read_clk        (clk),
    .i_read_rst_n      (rst_n),
    .i_clear           (bus.clear),
    .i_cmd_valid       (bus.cmd_valid),
    .o_cmd_ready       (bus.cmd_ready),
    .i_cmd_pointer     (bus.cmd_pointer),
    .i_cmd_length      (bus.cmd_length),
    .o_read_valid      (bus.read_valid),
    .i_read_ready      (bus.read_ready),
    .o_read_pointer    (bus.read_pointer),
    .o_read_info       (bus.read_info),
    .i_read_data_valid (bus.read_data_valid),
    .o_read_data_ready (bus.read_data_ready),
    .i_read_data       (bus.read_data),
    .i_read_info       (bus.read_data_info),
    .o_data_valid      (bus.data_valid),
    .i_data_ready      (bus.data_ready),
    .o_data            (bus.data),
    .o_last            (bus.last),
    .o_busy            (bus.busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM + output FIFO model: word at address p reads as 0xD000_0000 | p.
  logic [32:0] sram_q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_q.delete();
      bus.read_data_valid <= 1'b0;
      bus.read_data       <= '0;
      bus.read_data_info  <= 1'b0;
    end else begin
      if (bus.read_data_valid && bus.data_ready && sram_q.size() != 0) void'(sram_q.pop_front());
      if (bus.clear) sram_q.delete();
      else if (bus.read_valid && bus.read_ready)
        sram_q.push_back({bus.read_info, 32'hD000_0000 | 32'(bus.read_pointer)});
      bus.read_data_valid <= (sram_q.size() != 0);
      bus.read_data       <= (sram_q.size() != 0) ? sram_q[0][31:0] : '0;
      bus.read_data_info  <= (sram_q.size() != 0) ? sram_q[0][32] : 1'b0;
    end
  end

  logic [7:0]  req_ptr[$];
  logic        req_info[$];
  int          req_cyc[$];
  logic [31:0] got_data[$];
  logic        got_last[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (bus.read_valid && bus.read_ready) begin
        req_ptr.push_back(bus.read_pointer);
        req_info.push_back(bus.read_info);
        req_cyc.push_back(cyc);
      end
      if (bus.data_valid && bus.data_ready) begin
        got_data.push_back(bus.data);
        got_last.push_back(bus.last);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    req_ptr.delete(); req_info.delete(); req_cyc.delete();
    got_data.delete(); got_last.delete();
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_cmd(input logic [7:0] ptr, input logic [7:0] len);
    bus.cmd_pointer = ptr;
    bus.cmd_length  = len;
    bus.cmd_valid   = 1'b1;
    step(1);
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned c;
    c = 0;
    do begin
      step(1);
      c++;
    end while (bus.busy && c < budget);
    check({tag, "_idle"}, bus.busy, 1'b0);
    check({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
  endtask

  task automatic check_burst(input string tag, input logic [7:0] p0, input int unsigned len);
    logic [7:0] p;
    check({tag, "_req_count"}, req_ptr.size(), len + 1);
    check({tag, "_word_count"}, got_data.size(), len + 1);
    for (int unsigned i = 0; i <= len; i++) begin
      p = p0 + 8'(i);
      if (i < req_ptr.size()) begin
        check($sformatf("%s_req_ptr[%0d]", tag, i), req_ptr[i], p);
        check($sformatf("%s_req_info[%0d]", tag, i), req_info[i], (i == len));
      end
      if (i < got_data.size()) begin
        check($sformatf("%s_data[%0d]", tag, i), got_data[i], 32'hD000_0000 | 32'(p));
        check($sformatf("%s_last[%0d]", tag, i), got_last[i], (i == len));
      end
    end
  endtask

  logic [7:0] held_ptr;
  logic       held_info;
  logic       stalled;

  initial begin
    rst_n           = 1'b0;
    bus.clear       = 1'b0;
    bus.cmd_valid   = 1'b0;
    bus.cmd_pointer = '0;
    bus.cmd_length  = '0;
    bus.read_ready  = 1'b1;
    bus.data_ready  = 1'b1;

    // Reset state
    step(2);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_read_valid", bus.read_valid, 1'b0);
    check("rst_read_pointer", bus.read_pointer, 8'h00);
    check("rst_read_info", bus.read_info, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    step(1);

    // Basic 4-word burst
    clear_logs();
    send_cmd(8'h10, 8'd3);
    check("b1_busy", bus.busy, 1'b1);
    check("b1_ignore_cmd_ready", bus.cmd_ready, 1'b0);
    wait_idle("b1", 50);
    check_burst("b1", 8'h10, 3);

    // Pointer wrap with no bubble
    clear_logs();
    send_cmd(8'hFE, 8'd2);
    wait_idle("b2", 50);
    check_burst("b2", 8'hFE, 2);
    if (req_cyc.size() == 3) check("b2_wrap_no_stall", req_cyc[2] - req_cyc[1], 1);

    // Credit limit with downstream stalled
    clear_logs();
    bus.data_ready = 1'b0;
    send_cmd(8'h20, 8'd7);
    step(10);
    check("b3_req_at_limit", req_ptr.size(), 4);
    check("b3_read_valid_low", bus.read_valid, 1'b0);
    check("b3_no_words", got_data.size(), 0);
    bus.data_ready = 1'b1;
    wait_idle("b3", 100);
    check_burst("b3", 8'h20, 7);

    // Simultaneous handshakes hold the count at 2, then refill to the limit
    clear_logs();
    bus.data_ready = 1'b0;
    send_cmd(8'h60, 8'd7);
    step(2);
    check("b4_two_issued", req_ptr.size(), 2);
    bus.data_ready = 1'b1;
    step(3);
    check("b4_steady_issued", req_ptr.size(), 5);
    check("b4_steady_delivered", got_data.size(), 3);
    bus.data_ready = 1'b0;
    step(8);
    check("b4_outstanding_max", req_ptr.size() - got_data.size(), 4);
    bus.data_ready = 1'b1;
    wait_idle("b4", 100);
    check_burst("b4", 8'h60, 7);

    // Random request backpressure: pointer/info hold while stalled
    clear_logs();
    bus.read_ready = 1'b0;
    send_cmd(8'h40, 8'd5);
    for (int unsigned k = 0; k < 200 && bus.busy; k++) begin
      stalled   = bus.read_valid && !bus.read_ready;
      held_ptr  = bus.read_pointer;
      held_info = bus.read_info;
      step(1);
      if (stalled && bus.read_valid) begin
        check("b5_stall_ptr", bus.read_pointer, held_ptr);
        check("b5_stall_info", bus.read_info, held_info);
      end
      bus.read_ready = 1'($urandom_range(0, 1));
    end
    bus.read_ready = 1'b1;
    wait_idle("b5", 50);
    check_burst("b5", 8'h40, 5);

    // Clear mid-issue after two of six requests
    clear_logs();
    send_cmd(8'h80, 8'd5);
    for (int unsigned k = 0; k < 20 && req_ptr.size() < 2; k++) step(1);
    check("c_two_issued", req_ptr.size(), 2);
    bus.clear = 1'b1;
    #1;
    check("c_read_valid_same_cycle", bus.read_valid, 1'b0);
    step(1);
    bus.clear = 1'b0;
    check("c_cmd_ready", bus.cmd_ready, 1'b1);
    check("c_busy", bus.busy, 1'b0);
    check("c_no_more_reqs", req_ptr.size(), 2);
    clear_logs();
    send_cmd(8'h90, 8'd0);
    wait_idle("c0", 50);
    check_burst("c0", 8'h90, 0);

    // Reset pulse during DRAIN
    clear_logs();
    bus.data_ready = 1'b0;
    send_cmd(8'hA0, 8'd1);
    step(4);
    check("r_in_drain_valid", bus.read_valid, 1'b0);
    check("r_in_drain_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("r_cmd_ready", bus.cmd_ready, 1'b1);
    check("r_read_valid", bus.read_valid, 1'b0);
    check("r_read_pointer", bus.read_pointer, 8'h00);
    check("r_read_info", bus.read_info, 1'b0);
    check("r_busy", bus.busy, 1'b0);
    step(1);
    rst_n = 1'b1;
    bus.data_ready = 1'b1;
    clear_logs();
    send_cmd(8'hB0, 8'd2);
    check("r_first_cmd_taken", bus.cmd_ready, 1'b0);
    wait_idle("r", 50);
    check_burst("r", 8'hB0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pzbcm_sram_reader.md
PZBCM_SRAM_READER -- requirements
Module: pzbcm_sram_reader

Interface
REQ-001 SHALL have parameter POINTER_WIDTH, default 8, meaning SRAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning SRAM word width.
REQ-003 SHALL have parameter LENGTH_WIDTH, default 8, meaning burst-length field width; a burst is length+1 words.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of requests issued but not yet delivered downstream (range 1..255).
REQ-005 SHALL have ports: i_read_clk  in  1  clock; i_read_rst_n  in  1  asynchronous active-low reset; i_clear  in  1  synchronous abort.
REQ-006 SHALL have command ports: i_cmd_valid  in  1; o_cmd_ready  out  1; i_cmd_pointer  in  POINTER_WIDTH  start word; i_cmd_length  in  LENGTH_WIDTH  words minus 1.
REQ-007 SHALL have SRAM request ports: o_read_valid  out  1; i_read_ready  in  1; o_read_pointer  out  POINTER_WIDTH; o_read_info  out  1  last-word flag.
REQ-008 SHALL have SRAM response ports: i_read_data_valid  in  1; o_read_data_ready  out  1; i_read_data  in  DATA_WIDTH; i_read_info  in  1  returned last flag.
REQ-009 SHALL have stream ports: o_data_valid  out  1; i_data_ready  in  1; o_data  out  DATA_WIDTH; o_last  out  1; o_busy  out  1  FSM not IDLE or outstanding nonzero.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, DRAIN.
REQ-011 SHALL assert o_cmd_ready only in IDLE; command accepted when i_cmd_valid && o_cmd_ready; transition IDLE->ISSUE next cycle, pointer register <= i_cmd_pointer, remaining register <= i_cmd_length.
REQ-012 SHALL, in ISSUE, drive o_read_valid = (outstanding < MAX_OUTSTANDING); o_read_pointer = pointer register; o_read_info = (remaining == 0).
REQ-013 SHALL hold o_read_pointer/o_read_info stable while o_read_valid && !i_read_ready.
REQ-014 SHALL, on request handshake, increment pointer modulo 2^POINTER_WIDTH (wrap 0xFF->0x00 at default) and decrement remaining; on handshake with remaining == 0, transition ISSUE->DRAIN.
REQ-015 SHALL transition DRAIN->IDLE in the cycle after the stream handshake with o_last == 1; zero-length-minus-one (length 0) burst issues exactly one request.
REQ-016 SHALL pass responses combinationally: o_data_valid = i_read_data_valid; o_data = i_read_data; o_last = i_read_info; o_read_data_ready = i_data_ready; zero added latency.
REQ-017 SHALL maintain outstanding counter: +1 on request handshake, -1 on stream handshake, unchanged when both occur in the same cycle; never exceeds MAX_OUTSTANDING, never underflows.
REQ-018 SHALL not issue a request while outstanding == MAX_OUTSTANDING, even if i_read_ready is high.
REQ-019 SHALL, on i_clear, return FSM to IDLE and zero outstanding, pointer and remaining in the next cycle; o_read_valid deasserts the same cycle i_clear is sampled high; i_clear also clears the SRAM FIFO externally.
REQ-020 SHALL ignore i_cmd_valid while not in IDLE.

Reset
REQ-021 SHALL, while i_read_rst_n is low: FSM IDLE, outstanding 0, pointer 0, remaining 0.
REQ-022 SHALL drive reset outputs: o_cmd_ready 1, o_read_valid 0, o_read_pointer 0, o_read_info 0, o_busy 0; stream outputs follow inputs per REQ-016.
REQ-023 SHALL abandon any burst on reset assertion mid-operation and accept a new command the first cycle after deassertion.

Structure
REQ-024 SHALL place the FSM state enum and a helper returning clog2(MAX_OUTSTANDING+1) in pzbcm_sram_pkg.
REQ-025 SHALL be a single module; the outstanding counter is a natural sub-module pzbcm_sram_reader_credit (up/down saturating counter with full flag).
REQ-026 SHALL connect directly to a pzbcm_sram_if in its initiator role, mapping read_info to the last flag, with MAX_OUTSTANDING set no larger than the SRAM output FIFO depth.

Verification
REQ-027 Command pointer 0x10, length 3, ready always high -> requests 0x10,0x11,0x12,0x13, o_read_info high only on 0x13, four stream words, o_last on fourth, FSM back to IDLE.
REQ-028 Pointer 0xFE, length 2 -> requests 0xFE,0xFF,0x00; no stall at wrap.
REQ-029 MAX_OUTSTANDING 4, i_data_ready low, length 7 -> exactly 4 requests then o_read_valid low; releasing i_data_ready resumes issue, 8 words total delivered in order.
REQ-030 Simultaneous request and stream handshakes with outstanding 2 -> outstanding remains 2; i_read_ready toggling randomly -> pointer held stable while stalled.
REQ-031 i_clear asserted mid-ISSUE after 2 of 6 requests -> o_read_valid low immediately, o_cmd_ready high next cycle, o_busy low; new command of length 0 completes with one word.
REQ-032 i_read_rst_n pulsed low during DRAIN -> all outputs at reset values; subsequent command completes normally.
